// File: rtl/spi_slave_mw.sv
`timescale 1ns/1ps
// Parametrised multi-word SPI slave: all four CPOL/CPHA modes, MSB/LSB order, one-word TX buffer.
// Define SPI_ERR_FLAGS_EN to build the tx_underrun / frame_err pulse logic; otherwise both are tied low.
module spi_slave_mw #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] TX_FILL     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;

  state_t                 state_q;
  logic                   cpol_q, cpha_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   busy_q;
  logic [DATA_WIDTH-1:0]  buf_q;
  logic                   buf_full_q, buf_full_d;
  logic                   tx_ready_q;
  logic                   tx_bit;

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise, start, in_frame, word_done, load, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge moves sclk away from the polarity latched at frame start.
  assign sclk_edge   = sclk_s ^ sclk_prev_q;
  assign lead_edge   = sclk_edge & (sclk_s ^ cpol_q);
  assign trail_edge  = sclk_edge & ~(sclk_s ^ cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign start     = (state_q == IDLE) && ss_fall;
  assign in_frame  = (state_q == ACTIVE) && !ss_rise;
  assign word_done = in_frame && sample_edge && (bit_cnt_q == LAST_BIT);
  assign load      = start || word_done;
  assign accept    = tx_valid && tx_ready_q;
  assign buf_full_d = accept | (buf_full_q & ~load);

  generate
    if (MSB_FIRST) begin : g_msb
      assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
      assign tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      assign tx_bit     = tx_shift_q[DATA_WIDTH-1];
    end else begin : g_lsb
      assign rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
      assign tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
      assign tx_bit     = tx_shift_q[0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q  <= '0;
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (shift_edge && (bit_cnt_q != '0)) begin
            // bit 0 is already on miso from the load, so the first shift edge of a word is skipped
            tx_shift_q <= tx_shift_d;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load)
        tx_shift_q <= buf_full_q ? buf_q : TX_FILL;
      if (accept)
        buf_q <= tx_data;
      buf_full_q <= buf_full_d;
      tx_ready_q <= ~buf_full_d;
    end
  end

  assign miso     = busy_q & tx_bit;
  assign miso_oe  = busy_q;
  assign busy     = busy_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_ERR_FLAGS_EN
  logic tx_underrun_q, frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_underrun_q <= load & ~buf_full_q;
      frame_err_q   <= (state_q == ACTIVE) && ss_rise && (bit_cnt_q != '0);
    end
  end

  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
`else
  assign tx_underrun = 1'b0;
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_mw.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_mw: an 8-bit MSB-first instance (TX_FILL=0xFF) and a 16-bit LSB-first instance.
module tb_spi_slave_mw;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic cpol, cpha, sclk, mosi, ss8, ss16;

  logic        miso8, oe8, txv8, txr8, rxv8, busy8, und8, ferr8;
  logic [7:0]  txd8, rxd8;
  logic        miso16, oe16, txv16, txr16, rxv16, busy16, und16, ferr16;
  logic [15:0] txd16, rxd16;

  int n_vec = 0;
  int n_err = 0;
  int und8_cnt = 0, ferr8_cnt = 0, und16_cnt = 0, ferr16_cnt = 0;
  logic [15:0] exp_q8[$];
  logic [15:0] exp_q16[$];
  logic [15:0] got;

  always #5 clk = ~clk;

  spi_slave_mw #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1), .TX_FILL(8'hFF)) dut8 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss(ss8), .mosi(mosi),
    .miso(miso8), .miso_oe(oe8), .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
    .rx_data(rxd8), .rx_valid(rxv8), .busy(busy8), .tx_underrun(und8), .frame_err(ferr8)
  );

  spi_slave_mw #(.DATA_WIDTH(16), .SYNC_STAGES(2), .MSB_FIRST(1'b0), .TX_FILL(16'h0000)) dut16 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss(ss16), .mosi(mosi),
    .miso(miso16), .miso_oe(oe16), .tx_data(txd16), .tx_valid(txv16), .tx_ready(txr16),
    .rx_data(rxd16), .rx_valid(rxv16), .busy(busy16), .tx_underrun(und16), .frame_err(ferr16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitors: each rx_valid pulse pops the next expected word.
  always @(negedge clk) begin
    if (rxv8 === 1'b1) begin
      if (exp_q8.size() == 0) check("rx8_unexpected", {24'd0, rxd8}, 32'hFFFF_FFFF);
      else check("rx8", {24'd0, rxd8}, {16'd0, exp_q8.pop_front()});
    end
    if (rxv16 === 1'b1) begin
      if (exp_q16.size() == 0) check("rx16_unexpected", {16'd0, rxd16}, 32'hFFFF_FFFF);
      else check("rx16", {16'd0, rxd16}, {16'd0, exp_q16.pop_front()});
    end
    if (und8 === 1'b1)   und8_cnt++;
    if (ferr8 === 1'b1)  ferr8_cnt++;
    if (und16 === 1'b1)  und16_cnt++;
    if (ferr16 === 1'b1) ferr16_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic word_xfer(input bit on16, input int nbits, input logic [15:0] mo, output logic [15:0] mi);
    int w;
    int idx;
    w  = on16 ? 16 : 8;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = on16 ? i : (w - 1 - i);
      if (!cpha) begin
        mosi = mo[idx];
        wait_clks(HALF);
        sclk = ~cpol;
        mi[idx] = on16 ? miso16 : miso8;
        wait_clks(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[idx];
        wait_clks(HALF);
        sclk = cpol;
        mi[idx] = on16 ? miso16 : miso8;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic frame_begin(input bit on16, input bit pol, input bit pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clks(10);
    if (on16) ss16 = 1'b0; else ss8 = 1'b0;
    wait_clks(10);
  endtask

  task automatic frame_end(input bit on16);
    wait_clks(6);
    if (on16) ss16 = 1'b1; else ss8 = 1'b1;
    wait_clks(10);
  endtask

  task automatic push(input bit on16, input logic [15:0] d);
    int t;
    t = 0;
    while (((on16 ? txr16 : txr8) !== 1'b1) && (t < 200)) begin
      wait_clks(1);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: tx_ready stayed 0, expected 1 within 200 cycles");
    end
    if (on16) begin txd16 = d; txv16 = 1'b1; end
    else begin txd8 = d[7:0]; txv8 = 1'b1; end
    wait_clks(1);
    txv8  = 1'b0;
    txv16 = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] modes_pol [3];
    logic [7:0] modes_pha [3];
    int e_und8, e_ferr8, e_und16, e_ferr16;

    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
    ss8 = 1'b1; ss16 = 1'b1;
    txv8 = 1'b0; txd8 = '0; txv16 = 1'b0; txd16 = '0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);

    check("rst_tx_ready8", {31'd0, txr8}, 32'd1);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_oe8", {31'd0, oe8}, 32'd0);
    check("rst_miso8", {31'd0, miso8}, 32'd0);
    check("rst_rx_data8", {24'd0, rxd8}, 32'd0);
    check("rst_tx_ready16", {31'd0, txr16}, 32'd1);

    // Mode 0: slave sends 0xA5 (miso bits 1,0,1,0,0,1,0,1), master sends 0x3C
    push(1'b0, 16'h00A5);
    check("buf_full_tx_ready8", {31'd0, txr8}, 32'd0);
    exp_q8.push_back(16'h003C);
    frame_begin(1'b0, 1'b0, 1'b0);
    check("start_busy8", {31'd0, busy8}, 32'd1);
    check("start_oe8", {31'd0, oe8}, 32'd1);
    check("start_tx_ready8", {31'd0, txr8}, 32'd1);
    word_xfer(1'b0, 8, 16'h003C, got);
    check("m0_miso", {16'd0, got}, 32'h00A5);
    frame_end(1'b0);
    check("end_busy8", {31'd0, busy8}, 32'd0);

    // Modes 1, 2, 3: slave 0x81, master 0x7E
    modes_pol[0] = 8'd0; modes_pha[0] = 8'd1;
    modes_pol[1] = 8'd1; modes_pha[1] = 8'd0;
    modes_pol[2] = 8'd1; modes_pha[2] = 8'd1;
    for (int m = 0; m < 3; m++) begin
      push(1'b0, 16'h0081);
      exp_q8.push_back(16'h007E);
      frame_begin(1'b0, modes_pol[m][0], modes_pha[m][0]);
      word_xfer(1'b0, 8, 16'h007E, got);
      check($sformatf("mode%0d_miso", m + 1), {16'd0, got}, 32'h0081);
      frame_end(1'b0);
    end

    // Three-word burst, mode 0, buffer refilled after each tx_ready
    push(1'b0, 16'h0011);
    exp_q8.push_back(16'h00A1);
    exp_q8.push_back(16'h00B2);
    exp_q8.push_back(16'h00C3);
    frame_begin(1'b0, 1'b0, 1'b0);
    push(1'b0, 16'h0022);
    word_xfer(1'b0, 8, 16'h00A1, got);
    check("burst_w0", {16'd0, got}, 32'h0011);
    push(1'b0, 16'h0033);
    word_xfer(1'b0, 8, 16'h00B2, got);
    check("burst_w1", {16'd0, got}, 32'h0022);
    word_xfer(1'b0, 8, 16'h00C3, got);
    check("burst_w2", {16'd0, got}, 32'h0033);
    frame_end(1'b0);

    // Empty buffer: two words of TX_FILL
    exp_q8.push_back(16'h0000);
    exp_q8.push_back(16'h000F);
    frame_begin(1'b0, 1'b0, 1'b0);
    word_xfer(1'b0, 8, 16'h0000, got);
    check("fill_w0", {16'd0, got}, 32'h00FF);
    word_xfer(1'b0, 8, 16'h000F, got);
    check("fill_w1", {16'd0, got}, 32'h00FF);
    frame_end(1'b0);

    // Aborted after 5 bits, then a clean frame receiving 0x5A
    frame_begin(1'b0, 1'b0, 1'b0);
    word_xfer(1'b0, 5, 16'h00FF, got);
    frame_end(1'b0);
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    push(1'b0, 16'h00C3);
    exp_q8.push_back(16'h005A);
    frame_begin(1'b0, 1'b0, 1'b0);
    word_xfer(1'b0, 8, 16'h005A, got);
    check("after_abort_miso", {16'd0, got}, 32'h00C3);
    frame_end(1'b0);

    // 16-bit LSB-first, mode 3
    push(1'b1, 16'h1234);
    exp_q16.push_back(16'hBEEF);
    frame_begin(1'b1, 1'b1, 1'b1);
    word_xfer(1'b1, 16, 16'hBEEF, got);
    check("w16_miso", {16'd0, got}, 32'h1234);
    frame_end(1'b1);

    // Reset in the middle of a 16-bit word, with a word sitting in the buffer
    frame_begin(1'b1, 1'b1, 1'b1);
    word_xfer(1'b1, 7, 16'hFFFF, got);
    push(1'b1, 16'hAAAA);
    check("mid_tx_ready16", {31'd0, txr16}, 32'd0);
    check("mid_busy16", {31'd0, busy16}, 32'd1);
    check("mid_oe16", {31'd0, oe16}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_busy16", {31'd0, busy16}, 32'd0);
    check("rstmid_oe16", {31'd0, oe16}, 32'd0);
    check("rstmid_miso16", {31'd0, miso16}, 32'd0);
    check("rstmid_tx_ready16", {31'd0, txr16}, 32'd1);
    check("rstmid_rx_data16", {16'd0, rxd16}, 32'd0);
    check("rstmid_rx_valid16", {31'd0, rxv16}, 32'd0);
    check("rstmid_rx_data8", {24'd0, rxd8}, 32'd0);
    ss16 = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);
    check("post_rst_busy16", {31'd0, busy16}, 32'd0);
    check("post_rst_tx_ready16", {31'd0, txr16}, 32'd1);

`ifdef SPI_ERR_FLAGS_EN
    e_und8 = 10; e_ferr8 = 1; e_und16 = 2; e_ferr16 = 0;
`else
    e_und8 = 0; e_ferr8 = 0; e_und16 = 0; e_ferr16 = 0;
`endif
    check("underrun8_count", und8_cnt, e_und8);
    check("frame_err8_count", ferr8_cnt, e_ferr8);
    check("underrun16_count", und16_cnt, e_und16);
    check("frame_err16_count", ferr16_cnt, e_ferr16);
    check("rx8_pending", exp_q8.size(), 32'd0);
    check("rx16_pending", exp_q16.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_mw.md
Name: spi_slave_mw

Overview:
Parametrised SPI slave, successor to the fixed 8-bit slave. Supports configurable word width, all four CPOL/CPHA modes with correct CPHA timing, and MSB- or LSB-first order. Frames may carry back-to-back multi-word bursts. Sits between an external SPI master and on-chip logic, with a buffered valid/ready TX interface and a pulsed RX interface. System clock must be at least 4x the sclk frequency.

Parameters:
DATA_WIDTH, 8, bits per SPI word (>=2).
SYNC_STAGES, 2, synchroniser depth for sclk/ss/mosi (>=2).
MSB_FIRST, 1, 1 = MSB shifted first on both lines, 0 = LSB first.
TX_FILL, 0, DATA_WIDTH-wide word sent when no TX word is buffered.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cpol  in  1  clock polarity, latched at frame start
cpha  in  1  clock phase, latched at frame start
sclk  in  1  SPI clock (async)
ss  in  1  slave select, active-low (async)
mosi  in  1  master-out data (async)
miso  out  1  slave-out data, 0 when deselected
miso_oe  out  1  1 while frame active (external tristate control)
tx_data  in  DATA_WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding buffer empty
rx_data  out  DATA_WIDTH  last received word
rx_valid  out  1  1-cycle pulse, rx_data updated
busy  out  1  frame active (synchronised ss low)
tx_underrun  out  1  1-cycle pulse, TX_FILL used (optional feature)
frame_err  out  1  1-cycle pulse, ss rose mid-word (optional feature)

Behaviour:
- Reset: all outputs 0 except tx_ready=1. Shift registers, bit counter, TX buffer and latched mode cleared. Synchronisers reset to sclk=0, ss=1. Reset mid-frame aborts the frame; activity resumes only on the next synchronised ss falling edge.
- Synchronisation: sclk, ss and mosi each pass through SYNC_STAGES flops. Edges are detected from the last two synchronised sclk samples.
- Leading edge = transition away from the latched cpol; trailing edge = transition back to it.
- Sample edge: leading if cpha=0, trailing if cpha=1. Shift edge is the other one.
- States: IDLE, ACTIVE.
  - IDLE->ACTIVE on synchronised ss fall. On this transition: latch cpol/cpha, clear bit_cnt, load the TX shifter from the buffer (or TX_FILL if empty), and set busy=miso_oe=1.
  - ACTIVE->IDLE on synchronised ss rise. Any partial RX word is discarded, with no rx_valid.
- Sample edge (ACTIVE): shift synchronised mosi into the RX shifter in the MSB_FIRST order, then bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH-1 before the increment: wrap bit_cnt to 0, copy the RX shifter to rx_data and pulse rx_valid on the next clk.
  - In the same cycle, reload the TX shifter for the next word of the burst.
- Shift edge (ACTIVE): advance the TX shifter only if bit_cnt!=0. Shift edges with bit_cnt==0 are ignored in both modes. This gives the correct first bit for CPHA=0 and CPHA=1 and correct word boundaries.
- miso = current TX shifter output bit while ACTIVE, else 0.
- TX buffer: one word.
  - tx_data is accepted when tx_valid&&tx_ready; tx_ready drops the next cycle.
  - The buffer is consumed on a TX shifter load, and tx_ready rises the next cycle.
  - If an accept and a load happen in the same cycle, the load uses the old content (or TX_FILL if empty) and the accepted word stays buffered.
- sclk edges while ss is high are ignored. A cpol/cpha change mid-frame has no effect until the next frame.

Optional Feature:
SPI_ERR_FLAGS_EN.
- Defined: tx_underrun pulses for 1 cycle on every shifter load that used TX_FILL. frame_err pulses for 1 cycle when ss rises in ACTIVE with bit_cnt!=0.
- Undefined: both ports exist but are tied to 0, and no related logic is built.

Test Plan:
- Mode 0, DATA_WIDTH=8, MSB_FIRST=1; buffer tx 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready=1 after frame start.
- Modes 1, 2, 3, each with tx 0x81 and master 0x7E -> master samples 0x81 and rx_data=0x7E in every mode.
- Burst of 3 words in one frame (mode 0), tx 0x11, 0x22, 0x33 supplied via handshake after each tx_ready -> master reads 0x11, 0x22, 0x33; three rx_valid pulses.
- Empty buffer, TX_FILL=0xFF, SPI_ERR_FLAGS_EN defined -> miso sends 0xFF; tx_underrun pulses once per word.
- ss deasserted after 5 bits -> no rx_valid; frame_err pulses once (with SPI_ERR_FLAGS_EN); next frame receives 0x5A correctly.
- DATA_WIDTH=16, MSB_FIRST=0, mode 3; tx 0x1234, master 0xBEEF LSB-first -> rx_data=0xBEEF; assert rst mid-word -> all outputs reset, tx_ready=1.
